banked_memory: RTL

Parametrised successor to the single-bank instruction/data memory. It serves an instruction-fetch read port and a data read/write port against NUM_BANKS word-interleaved, single-ported banks, with byte-enable writes. Same-bank collisions are arbitrated with data priority and a starvation guard for fetch. It sits between the fetch unit and the data bus, in the position of the existing memory.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/mem_bank.sv | 35 +++
 rtl/banked_memory.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants, port bundle types and helpers for the banked instruction/data memory.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH  = 32;
  localparam int MEM_DATA_WIDTH  = 32;
  localparam int MEM_DEPTH_WORDS = 4096;
  localparam int MEM_NUM_BANKS   = 2;

  // A single bank has no bank-select bits in the address.
  function automatic int bank_bits(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  localparam int BANK_BITS = bank_bits(MEM_NUM_BANKS);
  localparam int ROW_BITS  = $clog2(MEM_DEPTH_WORDS / MEM_NUM_BANKS);
  localparam int BE_WIDTH  = MEM_DATA_WIDTH / 8;

  typedef struct packed {
    logic                      req;
    logic [MEM_ADDR_WIDTH-1:0] addr;
  } if2mem_t;

  typedef struct packed {
    logic                      ack;
    logic                      err;
    logic [MEM_DATA_WIDTH-1:0] rdata;
  } mem2if_t;

  typedef struct packed {
    logic                      req;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      wen;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]       be;
  } dbus2peri_t;

  typedef struct packed {
    logic                      ack;
    logic                      err;
    logic [MEM_DATA_WIDTH-1:0] rdata;
  } peri2dbus_t;

endpackage

// File: rtl/mem_bank.sv
// Single-port word array with byte-lane write enables and a registered read port.
module mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 2048,
  parameter int ROW_W      = $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ROW_W-1:0]        row,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [ROWS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read data on a write cycle is the old word; the top discards it.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem_q[row][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem_q[row];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_memory.sv
// Word-interleaved fetch + data memory with data-priority arbitration and a fetch starvation guard.
// Optional MEM_ADDR_CHECK_EN: flag out-of-range / misaligned accesses with err and suppress their writes.
module banked_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 4096,
  parameter int NUM_BANKS    = 2,
  parameter int MAX_IF_STALL = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    dmem_sel,
  input  logic                    d_req,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err
);

  localparam int BANK_W  = bank_bits(NUM_BANKS);
  localparam int BANK_IW = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROWS    = DEPTH_WORDS / NUM_BANKS;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int IDX_TOP = 2 + BANK_W + ROW_W;
  localparam int STALL_W = (MAX_IF_STALL > 0) ? $clog2(MAX_IF_STALL + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_IF_STALL);

  logic [BANK_IW-1:0] if_bank, d_bank;
  logic [ROW_W-1:0]   if_row, d_row;
  logic               if_bad, d_bad;
  logic               unused_addr_bits;

  assign if_row = if_addr[2+BANK_W +: ROW_W];
  assign d_row  = d_addr[2+BANK_W +: ROW_W];
  assign unused_addr_bits = ^{if_addr, d_addr};

  generate
    if (BANK_W > 0) begin : g_bank_sel
      assign if_bank = if_addr[2 +: BANK_W];
      assign d_bank  = d_addr[2 +: BANK_W];
    end else begin : g_one_bank
      assign if_bank = '0;
      assign d_bank  = '0;
    end
  endgenerate

`ifdef MEM_ADDR_CHECK_EN
  generate
    if (ADDR_WIDTH > IDX_TOP) begin : g_range_chk
      assign if_bad = (|if_addr[ADDR_WIDTH-1:IDX_TOP]) | (|if_addr[1:0]);
      assign d_bad  = (|d_addr[ADDR_WIDTH-1:IDX_TOP])  | (|d_addr[1:0]);
    end else begin : g_align_chk
      assign if_bad = |if_addr[1:0];
      assign d_bad  = |d_addr[1:0];
    end
  endgenerate
`else
  assign if_bad = 1'b0;
  assign d_bad  = 1'b0;
`endif

  logic               if_gnt, d_gnt, collide;
  logic [STALL_W-1:0] stall_d, stall_q;
  logic               if_ack_d, if_ack_q, if_err_d, if_err_q;
  logic               d_ack_d, d_ack_q, d_err_d, d_err_q, d_rd_d, d_rd_q;
  logic [BANK_IW-1:0] if_bank_d, if_bank_q, d_bank_d, d_bank_q;

  always_comb begin
    collide = if_req & d_req & dmem_sel & (if_bank == d_bank);
    if_gnt  = if_req & (~collide | (stall_q == STALL_MAX));
    d_gnt   = d_req & dmem_sel & (~collide | (stall_q != STALL_MAX));

    stall_d = stall_q;
    if (!if_req || if_gnt) stall_d = '0;
    else if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;

    if_ack_d  = if_gnt;
    if_err_d  = if_gnt & if_bad;
    if_bank_d = if_bank;
    d_ack_d   = d_gnt;
    d_err_d   = d_gnt & d_bad;
    d_rd_d    = d_gnt & ~d_wen & ~d_bad;
    d_bank_d  = d_bank;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q   <= '0;
      if_ack_q  <= 1'b0;
      if_err_q  <= 1'b0;
      if_bank_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rd_q    <= 1'b0;
      d_bank_q  <= '0;
    end else begin
      stall_q   <= stall_d;
      if_ack_q  <= if_ack_d;
      if_err_q  <= if_err_d;
      if_bank_q <= if_bank_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rd_q    <= d_rd_d;
      d_bank_q  <= d_bank_d;
    end
  end

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  // Arbitration guarantees at most one port hits a given bank per cycle.
  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic d_hit, if_hit;
      assign d_hit  = d_gnt & (d_bank == BANK_IW'(b));
      assign if_hit = if_gnt & (if_bank == BANK_IW'(b));

      mem_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ROWS      (ROWS),
        .ROW_W     (ROW_W)
      ) u_bank (
        .clk  (clk),
        .en   (d_hit | if_hit),
        .we   (d_hit & d_wen & ~d_bad & rst_n),
        .be   (d_be),
        .row  (d_hit ? d_row : if_row),
        .wdata(d_wdata),
        .rdata(bank_rdata[b])
      );
    end
  endgenerate

  assign if_ack   = if_ack_q;
  assign if_err   = if_err_q;
  assign if_rdata = (if_ack_q & ~if_err_q) ? bank_rdata[if_bank_q] : '0;
  assign d_ack    = d_ack_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rd_q ? bank_rdata[d_bank_q] : '0;

endmodule
